fetch_stage: RTL and testbench

//   Instruction fetch stage that sits directly upstream of decode_instruction.

---
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// instruction memory, buffers {instr, pc} in a small FIFO and hands them to
// decode over valid/ready. Branch redirects flush the buffer and restart fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;  // FIFO pointer width
    localparam int CW = $clog2(DEPTH + 1);                // occupancy count width
    localparam int OW = CW + 1;                           // headroom for count+inflight

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic              epoch_q, epoch_d;
    logic              req_epoch_q, req_epoch_d;   // epoch the outstanding request was issued in
    logic [31:0]       req_pc_q, req_pc_d;         // PC of the outstanding request
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0][31:0] instr_q;
    logic [DEPTH-1:0][31:0] pcbuf_q;

    logic              pop;
    logic              resp;
    logic              push;
    logic              issue;
    logic [OW-1:0]     occ;

    // Handshake, response acceptance and issue decisions for this cycle.
    always_comb begin
        pop   = if_valid && if_ready;
        // A response only counts when a request is actually outstanding.
        resp  = imem_rvalid && inflight_q;
        // Stale responses (issued before the last redirect) and anything that
        // lands in a redirect cycle are dropped; the flush takes precedence.
        push  = resp && (req_epoch_q == epoch_q) && !redirect_valid;
        // Slots already committed after this cycle's pop; issuing only while
        // this is below DEPTH guarantees a push can never overflow.
        occ   = OW'(count_q) + OW'(inflight_q) - OW'(pop);
        issue = (state_q == S_RUN) && !reset && !redirect_valid
                && (occ < OW'(DEPTH));
    end

    // Next-state logic for the FSM, PC, request tracking and FIFO pointers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inflight_d  = inflight_q;
        epoch_d     = epoch_q;
        req_epoch_d = req_epoch_q;
        req_pc_d    = req_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase

        // Request bookkeeping: issue wins over a same-cycle response so the
        // back-to-back case keeps exactly one request outstanding.
        if (issue) begin
            inflight_d  = 1'b1;
            req_epoch_d = epoch_q;
            req_pc_d    = pc_q;
        end else if (resp) begin
            inflight_d  = 1'b0;
        end

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'h0000_0003;
            epoch_d  = ~epoch_q;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'(PC_STEP);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
            req_pc_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            req_epoch_q <= req_epoch_d;
            req_pc_q    <= req_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage: cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            pcbuf_q <= '0;
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata;
            pcbuf_q[wr_ptr_q] <= req_pc_q;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = instr_q[rd_ptr_q];
    assign if_pc     = pcbuf_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized phase,
// checked against a stream-level model (delivered PCs are sequential from the
// latest reset/redirect target, each paired with the memory word at that PC).
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        spur;

    // Second instance with a PC near the top of the address space.
    logic        reset_w;
    logic        req_w;
    logic [31:0] addr_w;
    logic        rvalid_w = 1'b0;
    logic [31:0] rdata_w  = '0;
    logic        redir_w;
    logic [31:0] rpc_w;
    logic        valid_w;
    logic        ready_w;
    logic [31:0] instr_w;
    logic [31:0] pc_w;

    int          errors = 0;
    int          checks = 0;
    int          hs     = 0;
    logic [31:0] exp_pc;
    bit          prev_stall;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset_w),
        .imem_req(req_w), .imem_addr(addr_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .redirect_valid(redir_w), .redirect_pc(rpc_w),
        .if_valid(valid_w), .if_ready(ready_w),
        .if_instr(instr_w), .if_pc(pc_w)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_8610;
        if (a == 32'h4) return 32'h0030_8193;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // 1-cycle memories; spur injects a response with no request behind it.
    always @(posedge clk) begin
        imem_rvalid <= imem_req | spur;
        imem_rdata  <= imem_req ? memfn(imem_addr) : 32'hDEAD_BEEF;
        rvalid_w    <= req_w;
        rdata_w     <= memfn(addr_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream model check for the settled current cycle, model update, advance.
    task automatic sb();
        if (!reset) begin
            if (prev_stall) chk("stall_hold_valid", 32'(if_valid), 32'd1);
            if (if_valid) begin
                chk("head_pc", if_pc, exp_pc);
                chk("head_instr", if_instr, memfn(exp_pc));
            end
            if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        prev_stall = !reset && !redirect_valid && if_valid && !if_ready;
        if (reset)                  exp_pc = 32'h0;
        else if (redirect_valid)    exp_pc = redirect_pc & ~32'h3;
        else if (if_valid && if_ready) begin
            exp_pc = exp_pc + 32'd4;
            hs++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; spur = 1'b0;
        reset_w = 1'b1; ready_w = 1'b1; redir_w = 1'b0; rpc_w = '0;
        exp_pc = '0; prev_stall = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        sb();

        // 1: first fetch timing from reset release
        reset = 1'b0;
        #1; chk("c0_req", 32'(imem_req), 32'd0); sb();
        #1; chk("c1_req", 32'(imem_req), 32'd1); chk("c1_addr", imem_addr, 32'd0); sb();
        #1; chk("c2_valid", 32'(if_valid), 32'd0); sb();
        #1; chk("c3_valid", 32'(if_valid), 32'd1);
            chk("c3_instr", if_instr, 32'h0000_8610); chk("c3_pc", if_pc, 32'd0); sb();
        #1; chk("c4_valid", 32'(if_valid), 32'd1);
            chk("c4_instr", if_instr, 32'h0030_8193); chk("c4_pc", if_pc, 32'd4); sb();

        // 2: decode stall for 5 cycles, then release
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; chk("stall_req", 32'(imem_req), 32'd0); chk("stall_valid", 32'(if_valid), 32'd1); sb();
        end
        if_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin #1; sb(); end

        // 3: redirect to 0x103 with the FIFO full, stale response injected
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin #1; sb(); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; spur = 1'b1;
        #1; chk("rd_n_req", 32'(imem_req), 32'd0); sb();
        redirect_valid = 1'b0; spur = 1'b0; if_ready = 1'b1;
        #1; chk("rd_n1_req", 32'(imem_req), 32'd1); chk("rd_n1_addr", imem_addr, 32'h100);
            chk("rd_n1_valid", 32'(if_valid), 32'd0); sb();
        #1; chk("rd_n2_valid", 32'(if_valid), 32'd0); sb();
        #1; chk("rd_n3_valid", 32'(if_valid), 32'd1); chk("rd_n3_pc", if_pc, 32'h100);
            chk("rd_n3_instr", if_instr, memfn(32'h100)); sb();
        for (int i = 0; i < 4; i++) begin #1; sb(); end

        // 5: reset pulse with a request outstanding and the FIFO non-empty
        reset = 1'b1;
        #1; sb();
        reset = 1'b0;
        #1; chk("rp1_valid", 32'(if_valid), 32'd0); chk("rp1_req", 32'(imem_req), 32'd0); sb();
        #1; chk("rp2_req", 32'(imem_req), 32'd1); chk("rp2_addr", imem_addr, 32'd0);
            chk("rp2_valid", 32'(if_valid), 32'd0); sb();
        #1; chk("rp3_valid", 32'(if_valid), 32'd0); sb();
        #1; chk("rp4_valid", 32'(if_valid), 32'd1); chk("rp4_pc", if_pc, 32'd0);
            chk("rp4_instr", if_instr, 32'h0000_8610); sb();
        for (int i = 0; i < 3; i++) begin #1; sb(); end

        // 6: back-to-back redirects, last one wins
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1; sb();
        redirect_pc = 32'h80;
        #1; chk("bb_n1_req", 32'(imem_req), 32'd0); sb();
        redirect_valid = 1'b0;
        #1; chk("bb_req", 32'(imem_req), 32'd1); chk("bb_addr", imem_addr, 32'h80); sb();
        #1; chk("bb_valid_gap", 32'(if_valid), 32'd0); sb();
        #1; chk("bb_valid", 32'(if_valid), 32'd1); chk("bb_pc", if_pc, 32'h80); sb();

        // 4: PC wrap on the high-reset instance
        reset_w = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 3) begin chk("wrap0_pc", pc_w, 32'hFFFF_FFF8); chk("wrap0_v", 32'(valid_w), 32'd1); end
            if (c == 4) begin chk("wrap1_pc", pc_w, 32'hFFFF_FFFC); chk("wrap1_in", instr_w, memfn(32'hFFFF_FFFC)); end
            if (c == 5) begin chk("wrap2_pc", pc_w, 32'h0000_0000); chk("wrap2_in", instr_w, 32'h0000_8610); end
            sb();
        end

        // Randomized phase: stalls, redirects, spurious responses, resets
        hs = 0;
        for (int i = 0; i < 800; i++) begin
            if_ready       = ($urandom % 10) < 7;
            redirect_valid = ($urandom % 20) == 0;
            redirect_pc    = $urandom & 32'h0000_0FFF;
            reset          = ($urandom % 100) == 0;
            #1;
            spur = !imem_req && (($urandom % 8) == 0);
            sb();
        end
        spur = 1'b0;
        chk("progress", 32'(hs > 150), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
